// File: rtl/rv_pkg.sv
// Shared RV32IC front-end definitions.
// Contents:
//   XLEN, HW        - architectural word and halfword widths
//   RVC_MASK        - low opcode bits that mark a full 32-bit instruction
//   fetch_state_e   - fetch_aligner control FSM encoding
//   is_rvc()        - 1 when a halfword starts a 16-bit compressed instruction
// Decode and the compressed expander import the same constants and function.
package rv_pkg;

  localparam int XLEN = 32;
  localparam int HW   = 16;
  localparam logic [1:0] RVC_MASK = 2'b11;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_RSP = 2'd1,
    DROP     = 2'd2
  } fetch_state_e;

  // Any low-bit pattern other than 2'b11 is a compressed instruction.
  function automatic logic is_rvc(input logic [HW-1:0] hw);
    return (hw[1:0] & RVC_MASK) != RVC_MASK;
  endfunction

endpackage

// File: rtl/hw_queue.sv
// Three-entry halfword shift queue feeding the instruction aligner.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   flush        - empty the queue this cycle (pushes are ignored)
//   pop1, pop2   - remove one / two entries from the head
//   push1, push2 - append din0 / din0 then din1 at the tail
//   din0, din1   - halfwords to append, din0 first
//   h0, h1       - head entry and the entry behind it
//   count        - number of valid entries, 0..3
// A pop and a push in the same cycle are both applied: the pop shifts the
// entries down first, then the push lands behind whatever remains. The caller
// guarantees capacity is never exceeded and pop/push requests are one-hot.
module hw_queue
  import rv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          pop1,
  input  logic          pop2,
  input  logic          push1,
  input  logic          push2,
  input  logic [HW-1:0] din0,
  input  logic [HW-1:0] din1,
  output logic [HW-1:0] h0,
  output logic [HW-1:0] h1,
  output logic [1:0]    count
);

  logic [HW-1:0] q0, q1, q2;
  logic [HW-1:0] s0, s1, s2;
  logic [HW-1:0] n0, n1, n2;
  logic [1:0]    cnt_pop;
  logic [1:0]    cnt_next;

  always_comb begin
    // Pop stage: shift surviving entries toward the head.
    s0      = q0;
    s1      = q1;
    s2      = q2;
    cnt_pop = count;
    if (pop2) begin
      s0      = q2;
      s1      = '0;
      s2      = '0;
      cnt_pop = count - 2'd2;
    end else if (pop1) begin
      s0      = q1;
      s1      = q2;
      s2      = '0;
      cnt_pop = count - 2'd1;
    end

    // Push stage: write behind the post-pop tail.
    n0       = s0;
    n1       = s1;
    n2       = s2;
    cnt_next = cnt_pop;
    if (push1 || push2) begin
      case (cnt_pop)
        2'd0:    n0 = din0;
        2'd1:    n1 = din0;
        2'd2:    n2 = din0;
        default: ;
      endcase
      cnt_next = cnt_pop + 2'd1;
    end
    if (push2) begin
      case (cnt_pop)
        2'd0:    n1 = din1;
        2'd1:    n2 = din1;
        default: ;
      endcase
      cnt_next = cnt_pop + 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q0    <= '0;
      q1    <= '0;
      q2    <= '0;
      count <= 2'd0;
    end else begin
      q0    <= n0;
      q1    <= n1;
      q2    <= n2;
      count <= cnt_next;
    end
  end

  assign h0 = q0;
  assign h1 = q1;

endmodule

// File: rtl/fetch_aligner.sv
// RV32IC instruction-fetch front end.
// Issues word-aligned reads, buffers returned halfwords in hw_queue and
// presents one whole instruction (32-bit, or 16-bit compressed) per handshake
// to decode. Handles word-straddling 32-bit instructions and PC redirects.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   imem_req, imem_addr    - one-cycle read request, word-aligned address
//   imem_rsp_valid, imem_rdata - read response (halfword 0 = bits[15:0])
//   redirect_valid, redirect_pc - flush and restart at redirect_pc (bit0 ignored)
//   inst_valid, inst_ready - instruction handshake to decode
//   inst_data, inst_pc, inst_is_c - instruction, its PC, compressed flag
//   fsm_state              - current control FSM state (observability)
// Handshake: an instruction transfers on a cycle where inst_valid and
// inst_ready are both 1; while inst_valid=1 and inst_ready=0 the instruction
// fields hold stable. inst_valid never depends on inst_ready.
module fetch_aligner
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_is_c,
  output logic [1:0]      fsm_state
);

  fetch_state_e    state, state_next;
  logic [XLEN-1:0] fetch_addr;
  logic [XLEN-1:0] head_pc;
  logic            skip_low;

  logic [HW-1:0]   qh0, qh1;
  logic [1:0]      qcount;
  logic            head_c;
  logic            consume;
  logic            pop1, pop2, push1, push2;
  logic [1:0]      pop_n;
  logic [1:0]      count_after_pop;
  logic            rsp_take;
  logic [HW-1:0]   din0;

  hw_queue u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .pop1  (pop1),
    .pop2  (pop2),
    .push1 (push1),
    .push2 (push2),
    .din0  (din0),
    .din1  (imem_rdata[31:16]),
    .h0    (qh0),
    .h1    (qh1),
    .count (qcount)
  );

  always_comb begin
    head_c    = is_rvc(qh0);
    inst_is_c = head_c;
    inst_data = head_c ? {16'h0000, qh0} : {qh1, qh0};
    inst_pc   = head_pc;
    // A compressed head needs one entry, a 32-bit head needs two.
    inst_valid = !rst && !redirect_valid &&
                 ((head_c && qcount != 2'd0) || (!head_c && qcount >= 2'd2));

    consume = inst_valid && inst_ready;
    pop1    = consume && head_c;
    pop2    = consume && !head_c;
    pop_n   = pop2 ? 2'd2 : (pop1 ? 2'd1 : 2'd0);
    count_after_pop = qcount - pop_n;

    // A response during a redirect belongs to the old stream.
    rsp_take = (state == WAIT_RSP) && imem_rsp_valid && !redirect_valid;
    push1    = rsp_take && skip_low;
    push2    = rsp_take && !skip_low;
    // When entering mid-word only the upper halfword is part of the stream.
    din0     = skip_low ? imem_rdata[31:16] : imem_rdata[15:0];

    // At most one word in flight; fetch only when a full word will fit.
    imem_req  = !rst && (state == RUN) && !redirect_valid &&
                (count_after_pop <= 2'd1);
    imem_addr = fetch_addr;
  end

  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      // An outstanding read whose data has not arrived must be swallowed.
      state_next = (state != RUN && !imem_rsp_valid) ? DROP : RUN;
    end else begin
      case (state)
        RUN:      if (imem_req)       state_next = WAIT_RSP;
        WAIT_RSP: if (imem_rsp_valid) state_next = RUN;
        DROP:     if (imem_rsp_valid) state_next = RUN;
        default:                      state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      fetch_addr <= RESET_PC & ~32'h3;
      skip_low   <= RESET_PC[1];
      head_pc    <= RESET_PC;
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        fetch_addr <= redirect_pc & ~32'h3;
        skip_low   <= redirect_pc[1];
        head_pc    <= redirect_pc & ~32'h1;
      end else begin
        if (rsp_take) begin
          fetch_addr <= fetch_addr + 32'd4;
          skip_low   <= 1'b0;
        end
        if (consume) begin
          head_pc <= head_pc + (head_c ? 32'd2 : 32'd4);
        end
      end
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_fetch_aligner.sv
// Self-checking bench for fetch_aligner.
// A word-addressed memory model answers requests after rsp_lat cycles. The
// reference model walks the program from the current PC (reset or redirect
// target), reading halfwords out of that memory and deciding 16/32-bit from
// the low opcode bits; every accepted instruction is compared against it.
// Directed tests add literal expectations from hand-worked examples.
module tb_fetch_aligner;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_is_c;
  logic [1:0]  fsm_state;

  always #5 clk = ~clk;

  fetch_aligner #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_is_c      (inst_is_c),
    .fsm_state      (fsm_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- memory model ----------------
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    if (mem.exists(w)) return mem[w];
    return 32'h0001_0001;
  endfunction

  function automatic logic [15:0] hw_at(logic [31:0] a);
    logic [31:0] w;
    w = mem_rd(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Expected {is_c, pc, data} of the instruction starting at pc.
  function automatic logic [64:0] exp_inst(logic [31:0] pc);
    logic [15:0] h;
    h = hw_at(pc);
    if (h[1:0] != 2'b11) return {1'b1, pc, 16'h0000, h};
    return {1'b0, pc, hw_at(pc + 32'd2), h};
  endfunction

  // ---------------- monitor / compare state ----------------
  int          cyc = 0;
  int          rsp_lat = 1;
  bit          busy = 1'b0;
  int          due = 0;
  logic [31:0] raddr = '0;
  logic [31:0] model_pc = RESET_PC;
  logic [31:0] exp_fetch = RESET_PC & ~32'h3;
  bit          prev_rst = 1'b1;
  bit          hold = 1'b0;
  logic [64:0] hold_v;
  logic [64:0] cur, e;
  int          req_cnt = 0;
  int          rst_low_cyc = 0;
  int          redir_cyc = 0;

  logic [31:0] req_log[$];
  int          req_cyc_q[$];
  int          rsp_cyc_q[$];
  int          valid_cyc_q[$];
  logic [64:0] act_q[$];
  int          act_cyc_q[$];
  logic [64:0] exp_q[$];

  // Memory responder: answers the outstanding request rsp_lat cycles later.
  always @(posedge clk) begin
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rdata     = '0;
    if (busy && cyc == due) begin
      imem_rsp_valid = 1'b1;
      imem_rdata     = mem_rd(raddr);
    end
  end

  // Compare process: samples mid-cycle, checks every meaningful output.
  always @(negedge clk) begin
    cur = {inst_is_c, inst_pc, inst_data};
    if (rst) begin
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_imem_req", imem_req, 0);
      model_pc  = RESET_PC;
      exp_fetch = RESET_PC & ~32'h3;
      busy      = 1'b0;
      hold      = 1'b0;
    end else begin
      if (prev_rst) rst_low_cyc = cyc;
      if (hold && !redirect_valid) begin
        chk("hold_valid", inst_valid, 1);
        chk("hold_stable", cur, hold_v);
      end
      if (inst_valid) valid_cyc_q.push_back(cyc);
      if (redirect_valid) begin
        chk("redirect_no_valid", inst_valid, 0);
        model_pc  = redirect_pc & ~32'h1;
        exp_fetch = redirect_pc & ~32'h3;
        redir_cyc = cyc;
      end else if (inst_valid && inst_ready) begin
        e = exp_inst(model_pc);
        chk("inst", cur, e);
        act_q.push_back(cur);
        act_cyc_q.push_back(cyc);
        model_pc = model_pc + (e[64] ? 32'd2 : 32'd4);
      end
      if (imem_req) begin
        chk("req_no_overlap", busy, 0);
        chk("req_addr", imem_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
        req_cnt++;
        req_log.push_back(imem_addr);
        req_cyc_q.push_back(cyc);
      end
      if (imem_rsp_valid) begin
        busy = 1'b0;
        rsp_cyc_q.push_back(cyc);
      end
      if (imem_req) begin
        busy  = 1'b1;
        due   = cyc + rsp_lat;
        raddr = imem_addr;
      end
      hold   = inst_valid && !inst_ready && !redirect_valid;
      hold_v = cur;
    end
    prev_rst = rst;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    req_cyc_q.delete();
    rsp_cyc_q.delete();
    valid_cyc_q.delete();
    act_q.delete();
    act_cyc_q.delete();
    req_cnt = 0;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    tick(3);
    clear_logs();
    rst = 1'b0;
  endtask

  task automatic do_redirect(logic [31:0] pc);
    clear_logs();
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_req(logic [31:0] a, int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == a) ok = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_lits(string name);
    chk({name, "_count"}, act_q.size() >= exp_q.size(), 1);
    foreach (exp_q[i]) begin
      if (i < act_q.size()) chk(name, act_q[i], exp_q[i]);
    end
    exp_q.delete();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    bit ok;
    int r5;

    // 1: single 32-bit instruction after reset
    mem.delete();
    mem[32'h0] = 32'h0050_0093;
    rsp_lat = 1;
    inst_ready = 1'b1;
    do_reset();
    tick(8);
    chk("t1_req_count", req_log.size() >= 1, 1);
    if (req_log.size() >= 1) begin
      chk("t1_first_addr", req_log[0], 32'h0);
      chk("t1_first_req_cycle", req_cyc_q[0], rst_low_cyc);
    end
    chk("t1_has_valid", (valid_cyc_q.size() >= 1) && (rsp_cyc_q.size() >= 1), 1);
    if (valid_cyc_q.size() >= 1 && rsp_cyc_q.size() >= 1)
      chk("t1_latency", valid_cyc_q[0], rsp_cyc_q[0] + 1);
    exp_q.push_back({1'b0, 32'h0, 32'h0050_0093});
    check_lits("t1_inst");

    // 2: two compressed instructions in one word
    mem.delete();
    mem[32'h0] = 32'h4501_4505;
    do_reset();
    tick(8);
    exp_q.push_back({1'b1, 32'h0, 32'h0000_4505});
    exp_q.push_back({1'b1, 32'h2, 32'h0000_4501});
    check_lits("t2_inst");
    chk("t2_req_count", req_log.size() >= 2, 1);
    if (req_log.size() >= 2) chk("t2_second_addr", req_log[1], 32'h4);

    // 3: 32-bit instruction straddling a word boundary
    mem.delete();
    mem[32'h0] = 32'h0093_4505;
    mem[32'h4] = 32'h1234_0050;
    rsp_lat = 2;
    do_reset();
    tick(14);
    exp_q.push_back({1'b1, 32'h0, 32'h0000_4505});
    exp_q.push_back({1'b0, 32'h2, 32'h0050_0093});
    exp_q.push_back({1'b1, 32'h6, 32'h0000_1234});
    check_lits("t3_inst");
    chk("t3_logs", (act_cyc_q.size() >= 2) && (rsp_cyc_q.size() >= 2), 1);
    if (act_cyc_q.size() >= 2 && rsp_cyc_q.size() >= 2)
      chk("t3_straddle_after_rsp2", act_cyc_q[1], rsp_cyc_q[1] + 1);

    // 4: redirect into the upper half of a word
    mem.delete();
    mem[32'h100] = 32'hABCD_4505;
    rsp_lat = 1;
    do_reset();
    tick(5);
    do_redirect(32'h102);
    tick(10);
    chk("t4_req_count", req_log.size() >= 1, 1);
    if (req_log.size() >= 1) chk("t4_first_addr", req_log[0], 32'h100);
    exp_q.push_back({1'b1, 32'h102, 32'h0000_ABCD});
    check_lits("t4_inst");

    // 5: redirect while the read of 0x8 is outstanding
    mem.delete();
    mem[32'h200] = 32'h0050_0093;
    rsp_lat = 3;
    do_reset();
    wait_req(32'h8, 60, ok);
    chk("t5_saw_req8", ok, 1);
    do_redirect(32'h200);
    tick(12);
    chk("t5_req_count", req_log.size() >= 1, 1);
    if (req_log.size() >= 1) begin
      chk("t5_first_addr", req_log[0], 32'h200);
      chk("t5_req_after_drop", req_cyc_q[0], redir_cyc + 3);
    end
    chk("t5_logs", (rsp_cyc_q.size() >= 2) && (valid_cyc_q.size() >= 1), 1);
    if (rsp_cyc_q.size() >= 2 && valid_cyc_q.size() >= 1)
      chk("t5_first_valid", valid_cyc_q[0], rsp_cyc_q[1] + 1);
    exp_q.push_back({1'b0, 32'h200, 32'h0050_0093});
    check_lits("t5_inst");

    // 6: backpressure with 32-bit instructions
    mem.delete();
    mem[32'h0] = 32'h0050_0093;
    mem[32'h4] = 32'h00A0_0113;
    mem[32'h8] = 32'h00F0_0193;
    mem[32'hC] = 32'h0140_0213;
    rsp_lat = 1;
    inst_ready = 1'b0;
    do_reset();
    tick(5);
    r5 = req_cnt;
    tick(5);
    chk("t6_req_le2", req_cnt <= 2, 1);
    chk("t6_req_stopped", req_cnt, r5);
    chk("t6_no_accept", act_q.size(), 0);
    @(negedge clk);
    chk("t6_held_inst", {inst_valid, inst_is_c, inst_pc, inst_data},
        {1'b1, 1'b0, 32'h0, 32'h0050_0093});
    @(posedge clk);
    #1;
    inst_ready = 1'b1;
    tick(20);
    exp_q.push_back({1'b0, 32'h0, 32'h0050_0093});
    exp_q.push_back({1'b0, 32'h4, 32'h00A0_0113});
    exp_q.push_back({1'b0, 32'h8, 32'h00F0_0193});
    exp_q.push_back({1'b0, 32'hC, 32'h0140_0213});
    check_lits("t6_inst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fetch_aligner.md
Name: fetch_aligner

Overview:
- Instruction-fetch front end for the RV32IC core. It sits directly upstream of the decode/control stage.
- Issues word-aligned reads to instruction memory and buffers the returned halfwords.
- Presents one whole instruction per handshake to decode: 32-bit, or 16-bit compressed flagged for the expander.
- Handles 32-bit instructions that straddle a word boundary, and PC redirects from branch/jump resolution.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset. Must be halfword aligned.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- imem_req  out  1  one-cycle request pulse
- imem_addr  out  32  request address, bits[1:0]=00
- imem_rsp_valid  in  1  response strobe; ≥1 cycle after the request
- imem_rdata  in  32  response word; halfword 0 = bits[15:0]
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  new PC; bit0 ignored
- inst_valid  out  1  instruction available
- inst_ready  in  1  decode accepts
- inst_data  out  32  instruction; upper 16 bits zero when compressed
- inst_pc  out  32  PC of inst_data
- inst_is_c  out  1  1 = 16-bit compressed

Behaviour:
- Only one clock: clk. rst is synchronous, active-high, sampled on the clk rising edge.
- Reset values:
  - inst_valid=0, imem_req=0, queue count=0
  - fetch_addr = RESET_PC & ~3; skip_low = RESET_PC[1]
  - head_pc = RESET_PC; pending=0, drop=0
- Reset mid-operation discards everything, including an outstanding response.
- Halfword queue: 3 entries, count 0..3.
  - Head entry H0 is at head_pc; H1 is next.
- Instruction presence (combinational from registers):
  - If count≥1 and H0[1:0]≠2'b11: compressed. inst_data = {16'h0, H0}, inst_is_c=1.
  - Else if count≥2: inst_data = {H1, H0}, inst_is_c=0.
  - Otherwise inst_valid=0.
  - inst_pc = head_pc.
- Consume on inst_valid & inst_ready:
  - Pop 1 or 2 entries.
  - head_pc += 2 or 4 (mod 2^32, wraps).
- Fetch issue:
  - imem_req=1 for one cycle when !pending & !drop & !redirect_valid & (count after this cycle's pop) ≤ 1.
  - Issuing sets pending=1. imem_addr = fetch_addr.
- Response handling, when pending & imem_rsp_valid:
  - Push both halfwords, low first.
  - If skip_low=1, push only the upper halfword, then clear skip_low.
  - fetch_addr += 4; pending=0.
  - Pop and push in the same cycle are both applied (pop first, then push). Capacity is never exceeded.
- Issue latency:
  - First imem_req occurs in the first cycle after rst deasserts.
  - Response in cycle N gives inst_valid=1 in cycle N+1.
  - Back-to-back requests: next imem_req at earliest the cycle after the response.
- Redirect (highest priority):
  - Same cycle: queue count=0, head_pc = redirect_pc & ~1, fetch_addr = redirect_pc & ~3, skip_low = redirect_pc[1].
  - No consume is counted and inst_valid is forced to 0 that cycle.
  - A response arriving the same cycle is discarded.
  - If pending without a response that cycle: set drop=1. The next imem_rsp_valid is discarded and clears drop.
  - The new request issues the cycle after drop clears, or the cycle after the redirect if nothing was outstanding.
- Backpressure: while inst_ready=0, inst_data, inst_pc and inst_is_c hold stable. Fetching continues only until count ≥2.
- Stray imem_rsp_valid with !pending & !drop: ignored.

Decomposition:
- Shared package (rv_pkg): XLEN=32, HW=16, RVC_MASK=2'b11, and an is_rvc(halfword) function. Decode and the compressed expander reuse these.
- One sub-module: hw_queue, a 3-entry halfword shift queue.
  - Inputs: push1/push2, pop1/pop2, flush.
  - Outputs: H0, H1, count.
- Control FSM lives in fetch_aligner with states RUN / WAIT_RSP / DROP.
- fetch_aligner does not expand compressed instructions; that is the next block downstream.

Test Plan:
- Reset, RESET_PC=0, memory returns 0x00500093:
  - imem_addr=0x0.
  - inst_data=0x00500093, inst_pc=0x0, inst_is_c=0, valid the cycle after the response.
- Word at 0x0 = 0x45014505, inst_ready=1:
  - 0x00004505 at pc 0x0 (is_c=1), then 0x00004501 at pc 0x2 (is_c=1).
  - Next imem_addr=0x4.
- Straddle: words 0x00934505 @0x0 and 0x12340050 @0x4:
  - c 0x4505 @0x0.
  - 0x00500093 @0x2 (is_c=0), valid only after the second response.
  - Then c 0x1234 @0x6.
- redirect_valid with redirect_pc=0x102, memory @0x100 = 0xABCD4505:
  - imem_addr=0x100.
  - First output is 0x0000ABCD: pc 0x102, is_c=1 (0xABCD[1:0]=01).
  - 0x4505 is never presented.
- Redirect to 0x200 while the request to 0x8 is outstanding, response 2 cycles later:
  - That response produces no inst_valid.
  - The next imem_req has addr 0x200.
- inst_ready=0 for 10 cycles with 32-bit instructions returned:
  - Outputs stable.
  - At most 2 requests are issued, then imem_req stays 0 until the queue drains.
